mem_wb_stage: RTL and testbench

- Pipeline register between the MEM stage (DataMemory output) and the register-file writeback port.
- Captures the raw DataRd word and applies load sign/zero extension per DMCtrl.
- Selects the final writeback value (ALU result, load data, PC+4) and registers it for WB.
- Supports stall and flush from the hazard unit, a valid bit, a forwarding tap for EX, and a sticky illegal-load-size flag.

---
 rtl/mem_wb_stage.sv | 112 +++++++++++
 tb/tb_mem_wb_stage.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_wb_stage.sv
// mem_wb_stage: MEM->WB pipeline register with load extension, writeback select and a sticky illegal-load flag.
// Optional macro RETIRE_COUNT_EN adds the 64-bit InstRet retired-instruction counter.
`default_nettype none

module mem_wb_stage #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  Stall,
  input  logic                  Flush,
  input  logic                  Valid_M,
  input  logic [XLEN-1:0]       DataRd_M,
  input  logic [XLEN-1:0]       ALURes_M,
  input  logic [XLEN-1:0]       PC4_M,
  input  logic [2:0]            DMCtrl_M,
  input  logic [1:0]            RUDataWrSrc_M,
  input  logic                  RUWr_M,
  input  logic [REG_ADDR_W-1:0] Rd_M,
  output logic                  Valid_W,
  output logic                  RUWr_W,
  output logic [REG_ADDR_W-1:0] Rd_W,
  output logic [XLEN-1:0]       RUDataWr_W,
  output logic                  FwdValid_W,
`ifdef RETIRE_COUNT_EN
  output logic [63:0]           InstRet,
`endif
  output logic                  IllegalLoad
);

  localparam logic [2:0] DM_LB  = 3'b000;
  localparam logic [2:0] DM_LH  = 3'b001;
  localparam logic [2:0] DM_LW  = 3'b010;
  localparam logic [2:0] DM_LBU = 3'b100;
  localparam logic [2:0] DM_LHU = 3'b101;

  localparam logic [1:0] SRC_ALU  = 2'b00;
  localparam logic [1:0] SRC_LOAD = 2'b01;
  localparam logic [1:0] SRC_PC4  = 2'b10;

  logic [XLEN-1:0] load_ext;
  logic            load_legal;
  logic [XLEN-1:0] wb_data;
  logic            wr_en;
  logic            illegal_now;

  always_comb begin
    load_ext   = '0;
    load_legal = 1'b1;
    case (DMCtrl_M)
      DM_LB:   load_ext = {{(XLEN-8){DataRd_M[7]}}, DataRd_M[7:0]};
      DM_LH:   load_ext = {{(XLEN-16){DataRd_M[15]}}, DataRd_M[15:0]};
      DM_LW:   load_ext = DataRd_M;
      DM_LBU:  load_ext = {{(XLEN-8){1'b0}}, DataRd_M[7:0]};
      DM_LHU:  load_ext = {{(XLEN-16){1'b0}}, DataRd_M[15:0]};
      default: load_legal = 1'b0;
    endcase
  end

  always_comb begin
    wb_data     = '0;
    illegal_now = 1'b0;
    case (RUDataWrSrc_M)
      SRC_ALU:  wb_data = ALURes_M;
      SRC_LOAD: begin
        wb_data     = load_ext;
        illegal_now = Valid_M & ~load_legal;
      end
      SRC_PC4:  wb_data = PC4_M;
      default:  illegal_now = Valid_M;
    endcase
  end

  // x0 is hardwired to zero, so writes to it never leave this stage enabled.
  assign wr_en = Valid_M & RUWr_M & (Rd_M != '0);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      Valid_W     <= 1'b0;
      RUWr_W      <= 1'b0;
      Rd_W        <= '0;
      RUDataWr_W  <= '0;
      IllegalLoad <= 1'b0;
    end else if (Flush) begin
      Valid_W <= 1'b0;
      RUWr_W  <= 1'b0;
    end else if (!Stall) begin
      Valid_W    <= Valid_M;
      RUWr_W     <= wr_en;
      Rd_W       <= Rd_M;
      RUDataWr_W <= wb_data;
      if (illegal_now)
        IllegalLoad <= 1'b1;
    end
  end

  assign FwdValid_W = RUWr_W;

`ifdef RETIRE_COUNT_EN
  // An instruction retires when it leaves W; a flush only kills the incoming one.
  always_ff @(posedge Clk) begin
    if (Reset)
      InstRet <= '0;
    else if (Valid_W && !Stall)
      InstRet <= InstRet + 64'd1;
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_mem_wb_stage.sv
// tb_mem_wb_stage: directed self-checking bench for mem_wb_stage.
`default_nettype none

module tb_mem_wb_stage;

  logic        Clk = 1'b0;
  logic        Reset, Stall, Flush, Valid_M, RUWr_M;
  logic [31:0] DataRd_M, ALURes_M, PC4_M;
  logic [2:0]  DMCtrl_M;
  logic [1:0]  RUDataWrSrc_M;
  logic [4:0]  Rd_M;
  logic        Valid_W, RUWr_W, FwdValid_W, IllegalLoad;
  logic [4:0]  Rd_W;
  logic [31:0] RUDataWr_W;
`ifdef RETIRE_COUNT_EN
  logic [63:0] InstRet;
`endif

  int passed = 0;
  int total  = 0;

  always #5 Clk = ~Clk;

  mem_wb_stage #(.XLEN(32), .REG_ADDR_W(5)) dut (
    .Clk(Clk), .Reset(Reset), .Stall(Stall), .Flush(Flush), .Valid_M(Valid_M),
    .DataRd_M(DataRd_M), .ALURes_M(ALURes_M), .PC4_M(PC4_M), .DMCtrl_M(DMCtrl_M),
    .RUDataWrSrc_M(RUDataWrSrc_M), .RUWr_M(RUWr_M), .Rd_M(Rd_M),
    .Valid_W(Valid_W), .RUWr_W(RUWr_W), .Rd_W(Rd_W), .RUDataWr_W(RUDataWr_W),
    .FwdValid_W(FwdValid_W),
`ifdef RETIRE_COUNT_EN
    .InstRet(InstRet),
`endif
    .IllegalLoad(IllegalLoad)
  );

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] data, input logic [31:0] alu,
                       input logic [31:0] pc4, input logic [2:0] dm, input logic [1:0] src,
                       input logic wr, input logic [4:0] rd);
    Valid_M = v; DataRd_M = data; ALURes_M = alu; PC4_M = pc4;
    DMCtrl_M = dm; RUDataWrSrc_M = src; RUWr_M = wr; Rd_M = rd;
  endtask

  task automatic test_reset();
    drive(1'b1, 32'hDEADBEEF, 32'h1, 32'h2, 3'b011, 2'b01, 1'b1, 5'd7);
    Reset = 1'b1; Stall = 1'b1; Flush = 1'b0;
    step();
    Reset = 1'b0; Stall = 1'b0;
    total++; if (Valid_W !== 1'b0) $display("FAIL reset_valid got %b exp 0", Valid_W); else passed++;
    total++; if (RUWr_W !== 1'b0) $display("FAIL reset_ruwr got %b exp 0", RUWr_W); else passed++;
    total++; if (Rd_W !== 5'd0) $display("FAIL reset_rd got %0d exp 0", Rd_W); else passed++;
    total++; if (RUDataWr_W !== 32'h0) $display("FAIL reset_data got %h exp 0", RUDataWr_W); else passed++;
    total++; if (IllegalLoad !== 1'b0) $display("FAIL reset_illegal got %b exp 0", IllegalLoad); else passed++;
  endtask

  task automatic test_load_ext();
    logic [2:0]  codes [4] = '{3'b101, 3'b001, 3'b010, 3'b100};
    logic [31:0] exps  [4] = '{32'h0000F080, 32'hFFFFF080, 32'h1234F080, 32'h00000080};
    drive(1'b1, 32'h000000F0, 32'h0, 32'h0, 3'b000, 2'b01, 1'b1, 5'd5);
    step();
    total++; if (RUDataWr_W !== 32'hFFFFFFF0) $display("FAIL lb_data got %h exp FFFFFFF0", RUDataWr_W); else passed++;
    total++; if (Rd_W !== 5'd5) $display("FAIL lb_rd got %0d exp 5", Rd_W); else passed++;
    total++; if (RUWr_W !== 1'b1 || FwdValid_W !== 1'b1) $display("FAIL lb_ruwr got %b/%b exp 1/1", RUWr_W, FwdValid_W); else passed++;
    total++; if (Valid_W !== 1'b1) $display("FAIL lb_valid got %b exp 1", Valid_W); else passed++;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h1234F080, 32'h0, 32'h0, codes[i], 2'b01, 1'b1, 5'd6);
      step();
      total++;
      if (RUDataWr_W !== exps[i]) $display("FAIL ext_dm%b got %h exp %h", codes[i], RUDataWr_W, exps[i]);
      else passed++;
    end
  endtask

  task automatic test_pc4_alu();
    drive(1'b1, 32'h0, 32'h55, 32'h00000104, 3'b011, 2'b10, 1'b1, 5'd1);
    step();
    total++; if (RUDataWr_W !== 32'h00000104) $display("FAIL pc4_data got %h exp 00000104", RUDataWr_W); else passed++;
    total++; if (RUWr_W !== 1'b1) $display("FAIL pc4_ruwr got %b exp 1", RUWr_W); else passed++;
    Rd_M = 5'd0;
    step();
    total++; if (RUWr_W !== 1'b0 || FwdValid_W !== 1'b0) $display("FAIL x0_ruwr got %b/%b exp 0/0", RUWr_W, FwdValid_W); else passed++;
    total++; if (Valid_W !== 1'b1) $display("FAIL x0_valid got %b exp 1", Valid_W); else passed++;
    drive(1'b1, 32'hFFFFFFFF, 32'h0000ABCD, 32'h4, 3'b111, 2'b00, 1'b1, 5'd2);
    step();
    total++; if (RUDataWr_W !== 32'h0000ABCD) $display("FAIL alu_data got %h exp 0000ABCD", RUDataWr_W); else passed++;
    total++; if (IllegalLoad !== 1'b0) $display("FAIL alu_dm_ignored got %b exp 0", IllegalLoad); else passed++;
    drive(1'b0, 32'h0, 32'h9, 32'h0, 3'b010, 2'b00, 1'b1, 5'd2);
    step();
    total++; if (Valid_W !== 1'b0 || RUWr_W !== 1'b0) $display("FAIL bubble got %b/%b exp 0/0", Valid_W, RUWr_W); else passed++;
  endtask

  task automatic test_stall_flush();
    drive(1'b1, 32'h0, 32'h7, 32'h0, 3'b000, 2'b00, 1'b1, 5'd3);
    step();
    Stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h0, 32'h99 + i, 32'h0, 3'b011, 2'b01, 1'b1, 5'd9);
      step();
      total++;
      if (RUDataWr_W !== 32'h7 || Rd_W !== 5'd3 || RUWr_W !== 1'b1 || Valid_W !== 1'b1 || IllegalLoad !== 1'b0)
        $display("FAIL stall_hold%0d got %h/%0d/%b/%b/%b exp 00000007/3/1/1/0",
                 i, RUDataWr_W, Rd_W, RUWr_W, Valid_W, IllegalLoad);
      else passed++;
    end
    Flush = 1'b1;
    step();
    total++; if (Valid_W !== 1'b0 || RUWr_W !== 1'b0) $display("FAIL stallflush got %b/%b exp 0/0", Valid_W, RUWr_W); else passed++;
    total++; if (RUDataWr_W !== 32'h7 || Rd_W !== 5'd3 || IllegalLoad !== 1'b0)
      $display("FAIL flush_keep got %h/%0d/%b exp 00000007/3/0", RUDataWr_W, Rd_W, IllegalLoad); else passed++;
    Stall = 1'b0; Flush = 1'b0;
  endtask

  task automatic test_illegal();
    drive(1'b0, 32'h12345678, 32'h0, 32'h0, 3'b011, 2'b01, 1'b1, 5'd4);
    step();
    total++; if (IllegalLoad !== 1'b0) $display("FAIL illegal_invalid got %b exp 0", IllegalLoad); else passed++;
    Valid_M = 1'b1;
    step();
    total++; if (IllegalLoad !== 1'b1) $display("FAIL illegal_set got %b exp 1", IllegalLoad); else passed++;
    total++; if (RUDataWr_W !== 32'h0 || RUWr_W !== 1'b1) $display("FAIL illegal_data got %h/%b exp 0/1", RUDataWr_W, RUWr_W); else passed++;
    drive(1'b1, 32'hCAFEF00D, 32'h0, 32'h0, 3'b010, 2'b01, 1'b1, 5'd4);
    step(); step();
    total++; if (IllegalLoad !== 1'b1 || RUDataWr_W !== 32'hCAFEF00D)
      $display("FAIL illegal_sticky got %b/%h exp 1/CAFEF00D", IllegalLoad, RUDataWr_W); else passed++;
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    total++; if (IllegalLoad !== 1'b0) $display("FAIL illegal_clear got %b exp 0", IllegalLoad); else passed++;
    drive(1'b1, 32'hFFFFFFFF, 32'h11, 32'h22, 3'b010, 2'b11, 1'b1, 5'd8);
    step();
    total++; if (IllegalLoad !== 1'b1 || RUDataWr_W !== 32'h0)
      $display("FAIL src11 got %b/%h exp 1/0", IllegalLoad, RUDataWr_W); else passed++;
  endtask

  task automatic test_reset_mid_stall();
    drive(1'b1, 32'h0, 32'h3C, 32'h0, 3'b000, 2'b00, 1'b1, 5'd10);
    step();
    Stall = 1'b1;
    step();
    Reset = 1'b1;
    step();
    Reset = 1'b0; Stall = 1'b0;
    total++; if (Valid_W !== 1'b0 || RUWr_W !== 1'b0 || RUDataWr_W !== 32'h0 || Rd_W !== 5'd0)
      $display("FAIL reset_midstall got %b/%b/%h/%0d exp 0/0/0/0", Valid_W, RUWr_W, RUDataWr_W, Rd_W); else passed++;
  endtask

`ifdef RETIRE_COUNT_EN
  task automatic test_retire();
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    total++; if (InstRet !== 64'd0) $display("FAIL instret_reset got %0d exp 0", InstRet); else passed++;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 32'h0, i, 32'h0, 3'b000, 2'b00, 1'b1, 5'd1);
      step();
    end
    Stall = 1'b1;
    step(); step();
    Stall = 1'b0;
    Valid_M = 1'b0;
    step();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 32'h0, i, 32'h0, 3'b000, 2'b00, 1'b1, 5'd1);
      step();
    end
    Valid_M = 1'b0;
    step(); step();
    total++; if (InstRet !== 64'd10) $display("FAIL instret_count got %0d exp 10", InstRet); else passed++;
    Valid_M = 1'b1;
    step();
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    total++; if (InstRet !== 64'd0 || Valid_W !== 1'b0)
      $display("FAIL instret_midreset got %0d/%b exp 0/0", InstRet, Valid_W); else passed++;
  endtask
`endif

  initial begin
    Reset = 1'b1; Stall = 1'b0; Flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 32'h0, 3'b000, 2'b00, 1'b0, 5'd0);
    #12;
    test_reset();
    test_load_ext();
    test_pc4_alu();
    test_stall_flush();
    test_illegal();
    test_reset_mid_stall();
`ifdef RETIRE_COUNT_EN
    test_retire();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
